div_sched_ctrl: RTL and testbench

DIV_SCHED_CTRL -- requirements
Module: div_sched_ctrl

---
 rtl/div_sched_ctrl.sv | 132 +++++++++++++
 tb/tb_div_sched_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_sched_ctrl.sv
// div_sched_ctrl: programmable clock-tick divider. The divisor can be changed
// at run time. A new divisor is applied only at a period boundary, so a period
// that is already in progress is never cut short or stretched.
//
// Ports
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   en          run enable (high = generate ticks, low = return to idle)
//   cfg_valid   new divisor offered on cfg_div
//   cfg_div     requested divisor N (0 is treated as 1)
//   cfg_ready   a divisor can be accepted this cycle
//   q           one-cycle tick every N cycles while running
//   running     high while in RUN or PEND
//   period_cnt  completed periods since the last start (saturates at 255)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | stopped, cnt held at 0, divisor loads directly
// RUN   | counting with div_reg, ready for a new divisor
// PEND  | counting, pend_div waits for the next period boundary
module div_sched_ctrl #(
   parameter int WIDTH   = 4,
   parameter int DEF_DIV = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             q,
   output logic             running,
   output logic [7:0]       period_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;

   localparam logic [WIDTH-1:0] DIV_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_DEF = WIDTH'(DEF_DIV);

   logic [1:0]       state;
   logic [WIDTH-1:0] div_reg;
   logic [WIDTH-1:0] pend_div;
   logic [WIDTH-1:0] cnt;
   logic [7:0]       period_q;

   logic             xfer;
   logic [WIDTH-1:0] cfg_val;
   logic             boundary;
   logic [7:0]       period_inc;

   assign xfer       = cfg_valid && cfg_ready;
   assign cfg_val    = (cfg_div == '0) ? DIV_ONE : cfg_div;
   // div_reg is never 0, so div_reg-1 never underflows
   assign boundary   = (cnt == (div_reg - DIV_ONE));
   assign period_inc = (period_q == 8'hFF) ? period_q : period_q + 8'd1;

   // All outputs decode registered state only
   assign running    = (state == S_RUN) || (state == S_PEND);
   assign cfg_ready  = (state != S_PEND);
   assign q          = running && (cnt == '0);
   assign period_cnt = period_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         div_reg  <= DIV_DEF;
         pend_div <= DIV_DEF;
         period_q <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (xfer)
                  div_reg <= cfg_val;
               if (en) begin
                  state    <= S_RUN;
                  period_q <= 8'd0;
               end
            end

            S_RUN: begin
               if (boundary)
                  period_q <= period_inc;
               if (!en) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  if (xfer)
                     div_reg <= cfg_val;
               end else if (boundary) begin
                  // Boundary transfer takes effect for the period starting now
                  cnt <= '0;
                  if (xfer)
                     div_reg <= cfg_val;
               end else begin
                  cnt <= cnt + DIV_ONE;
                  if (xfer) begin
                     pend_div <= cfg_val;
                     state    <= S_PEND;
                  end
               end
            end

            S_PEND: begin
               if (boundary)
                  period_q <= period_inc;
               if (!en) begin
                  // A stop commits the waiting divisor rather than dropping it
                  state   <= S_IDLE;
                  cnt     <= '0;
                  div_reg <= pend_div;
               end else if (boundary) begin
                  state   <= S_RUN;
                  cnt     <= '0;
                  div_reg <= pend_div;
               end else begin
                  cnt <= cnt + DIV_ONE;
               end
            end

            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed bench for div_sched_ctrl: each step drives the inputs for one cycle,
// queues the outputs expected in that cycle and checks them against the DUT.
module tb_div_sched_ctrl;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       cfg_valid;
   logic [3:0] cfg_div;
   logic       cfg_ready;
   logic       q;
   logic       running;
   logic [7:0] period_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic  q;
      logic  run;
      logic  rdy;
      string tag;
   } exp_t;

   exp_t sb[$];

   div_sched_ctrl #(.WIDTH(4), .DEF_DIV(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_div    (cfg_div),
      .cfg_ready  (cfg_ready),
      .q          (q),
      .running    (running),
      .period_cnt (period_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic e, input logic v, input logic [3:0] d,
                       input logic eq, input logic er, input logic ey,
                       input string tag);
      exp_t x;
      en        = e;
      cfg_valid = v;
      cfg_div   = d;
      sb.push_back('{eq, er, ey, tag});
      #1;
      x = sb.pop_front();
      total++;
      assert (q === x.q) else begin
         bad++;
         $error("FAIL %s q got %b want %b", x.tag, q, x.q);
      end
      total++;
      assert (running === x.run) else begin
         bad++;
         $error("FAIL %s running got %b want %b", x.tag, running, x.run);
      end
      total++;
      assert (cfg_ready === x.rdy) else begin
         bad++;
         $error("FAIL %s cfg_ready got %b want %b", x.tag, cfg_ready, x.rdy);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_pc(input logic [7:0] e, input string tag);
      total++;
      assert (period_cnt === e) else begin
         bad++;
         $error("FAIL %s period_cnt got %0d want %0d", tag, period_cnt, e);
      end
   endtask

   task automatic chk_reset(input string tag);
      total++;
      assert (q === 1'b0 && running === 1'b0 && cfg_ready === 1'b1 && period_cnt === 8'd0)
      else begin
         bad++;
         $error("FAIL %s q/run/rdy/pc got %b%b%b/%0d want 001/0", tag,
                q, running, cfg_ready, period_cnt);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 4'd0;
      @(negedge clk);
      chk_reset("reset");
      reset_n = 1'b1;

      // Default divisor 3, ticks in RUN cycles 1, 4, 7
      step(1, 0, 0, 0, 0, 1, "a_idle");
      for (int i = 0; i < 9; i++) step(1, 0, 0, (i % 3) == 0, 1, 1, "a_run");
      chk_pc(8'd3, "a_pc");
      step(0, 0, 0, 1, 1, 1, "a_stop");
      step(0, 0, 0, 0, 0, 1, "a_idle2");
      chk_pc(8'd3, "a_pc_hold");

      // IDLE load of 5, then of 0 (stored as 1)
      step(0, 1, 5, 0, 0, 1, "b_cfg5");
      step(1, 0, 0, 0, 0, 1, "b_start");
      chk_pc(8'd0, "b_pc_clr");
      for (int i = 0; i < 10; i++) step(1, 0, 0, (i % 5) == 0, 1, 1, "b_run5");
      chk_pc(8'd2, "b_pc");
      step(0, 0, 0, 1, 1, 1, "b_stop");
      step(0, 1, 0, 0, 0, 1, "b_cfg0");
      step(1, 0, 0, 0, 0, 1, "b_start1");
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 1, "b_run1");
      chk_pc(8'd4, "b_pc1");
      step(0, 0, 0, 1, 1, 1, "b_stop1");

      // N=4, offer 2 at cnt=1: PEND two cycles, offer in PEND ignored
      step(0, 1, 4, 0, 0, 1, "c_cfg4");
      step(1, 0, 0, 0, 0, 1, "c_start");
      step(1, 0, 0, 1, 1, 1, "c_c0");
      step(1, 1, 2, 0, 1, 1, "c_offer");
      step(1, 1, 9, 0, 1, 0, "c_pend1");
      step(1, 0, 0, 0, 1, 0, "c_pend2");
      for (int i = 0; i < 4; i++) step(1, 0, 0, (i % 2) == 0, 1, 1, "c_run2");
      chk_pc(8'd3, "c_pc");
      step(0, 0, 0, 1, 1, 1, "c_stop");

      // N=3, offer 6 at the boundary: applied immediately, stays RUN
      step(0, 1, 3, 0, 0, 1, "d_cfg3");
      step(1, 0, 0, 0, 0, 1, "d_start");
      step(1, 0, 0, 1, 1, 1, "d_c0");
      step(1, 0, 0, 0, 1, 1, "d_c1");
      step(1, 1, 6, 0, 1, 1, "d_offer");
      for (int i = 0; i < 6; i++) step(1, 0, 0, i == 0, 1, 1, "d_run6");
      chk_pc(8'd2, "d_pc");
      step(0, 0, 0, 1, 1, 1, "d_stop");

      // Stop while pend_div=7 waits: 7 must be used on restart
      step(0, 1, 4, 0, 0, 1, "e_cfg4");
      step(1, 0, 0, 0, 0, 1, "e_start");
      step(1, 1, 7, 1, 1, 1, "e_offer");
      step(0, 0, 0, 0, 1, 0, "e_stop_pend");
      step(0, 0, 0, 0, 0, 1, "e_idle");
      chk_pc(8'd0, "e_pc0");
      step(1, 0, 0, 0, 0, 1, "e_restart");
      for (int i = 0; i < 7; i++) step(1, 0, 0, i == 0, 1, 1, "e_run7");
      chk_pc(8'd1, "e_pc");

      // Reset in PEND mid-period: pending divisor dropped, default 3 restored
      step(1, 1, 2, 1, 1, 1, "f_offer");
      step(1, 0, 0, 0, 1, 0, "f_pend");
      reset_n = 1'b0;
      #1;
      chk_reset("f_reset");
      @(negedge clk);
      chk_reset("f_reset_hold");
      reset_n = 1'b1;
      step(1, 0, 0, 0, 0, 1, "f_start");
      for (int i = 0; i < 3; i++) step(1, 0, 0, i == 0, 1, 1, "f_run3");
      step(1, 0, 0, 1, 1, 1, "f_c0");
      step(0, 0, 0, 0, 1, 1, "f_stop");
      step(0, 0, 0, 0, 0, 1, "f_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
